// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA write path: scheduler states and defaults.
package vdma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    WAIT_DATA,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam int BURST_LEN_DEF = 16;
  localparam int BPB_DEF       = 4;
  localparam int FB_NUM_DEF    = 3;

  // Burst length clamp: never run past the end of the line.
  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wr_addr_gen.sv
// Burst start address generator. One register stage: the address for the
// current buffer/line/offset is ready the cycle after those values settle,
// and it is frozen while a command is being offered.
module wr_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int BPB    = vdma_pkg::BPB_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_stride,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [1:0]        fidx,
  input  logic [15:0]       line,
  input  logic [15:0]       offset,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_nx;

  // All terms wrap modulo 2^ADDR_W.
  always_comb begin
    addr_nx = base_addr
            + ADDR_W'(fidx)   * frame_stride
            + ADDR_W'(line)   * line_stride
            + ADDR_W'(offset) * ADDR_W'(BPB);
  end

  // Pipeline register; holds while the command is outstanding.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)  addr <= '0;
    else if (en) addr <= addr_nx;
  end

endmodule

// File: rtl/wr_burst_sched.sv
// Write burst scheduler: walks a frame line by line in bursts of up to
// BURST_LEN beats, gating each burst on FIFO fill, and rotates through
// FB_NUM frame buffers. Handles mid-frame falign by restarting in the next
// buffer once any outstanding burst has completed.
module wr_burst_sched #(
  parameter int BURST_LEN = vdma_pkg::BURST_LEN_DEF,
  parameter int ADDR_W    = 32,
  parameter int BPB       = vdma_pkg::BPB_DEF,
  parameter int FB_NUM    = vdma_pkg::FB_NUM_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       vactive,
  input  logic [15:0]       hactive,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_stride,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic              falign,
  input  logic [11:0]       fifo_count,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              burst_done,
  output logic [1:0]        frame_idx,
  output logic              frame_done,
  output logic              resync_err,
  output logic              cfg_err
);
  import vdma_pkg::*;

  localparam logic [15:0] BL      = 16'(BURST_LEN);
  localparam logic [1:0]  FB_LAST = 2'(FB_NUM - 1);

  state_t            state;
  logic [15:0]       hact, vact, line, offset;
  logic [ADDR_W-1:0] fstride, lstride;
  logic              pend;

  logic [15:0]       len, offset_nx;
  logic              eol, last_burst, data_ok;
  logic [1:0]        fidx_nx;

  assign cfg_err = (hactive == 16'd0) || (vactive == 16'd0);

  // Current burst size and where it leaves us in the frame.
  always_comb begin
    len        = min16(BL, hact - offset);
    offset_nx  = offset + len;
    eol        = (offset_nx >= hact);
    last_burst = eol && ((line + 16'd1) == vact);
    data_ok    = ({4'd0, fifo_count} >= len);
    fidx_nx    = (frame_idx == FB_LAST) ? 2'd0 : frame_idx + 2'd1;
  end

  wr_addr_gen #(
    .ADDR_W (ADDR_W),
    .BPB    (BPB)
  ) u_addr (
    .clock        (clock),
    .rst_n        (rst_n),
    .en           (state != ISSUE),
    .base_addr    (base_addr),
    .frame_stride (fstride),
    .line_stride  (lstride),
    .fidx         (frame_idx),
    .line         (line),
    .offset       (offset),
    .addr         (cmd_addr)
  );

  // Scheduler FSM with registered command and status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_valid  <= 1'b0;
      cmd_len    <= '0;
      frame_idx  <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
      line       <= '0;
      offset     <= '0;
      pend       <= 1'b0;
      hact       <= '0;
      vact       <= '0;
      fstride    <= '0;
      lstride    <= '0;
    end else begin
      frame_done <= 1'b0;
      resync_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (falign && !cfg_err) begin
            line    <= '0;
            offset  <= '0;
            hact    <= hactive;
            vact    <= vactive;
            fstride <= frame_stride;
            lstride <= line_stride;
            state   <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (!enable) begin
            state <= IDLE;
          end else if (falign) begin
            // Frame restarted under us: abandon this buffer, begin the next.
            resync_err <= 1'b1;
            frame_idx  <= fidx_nx;
            line       <= '0;
            offset     <= '0;
            hact       <= hactive;
            vact       <= vactive;
            fstride    <= frame_stride;
            lstride    <= line_stride;
            state      <= cfg_err ? WAIT_FRAME : WAIT_DATA;
          end else if (data_ok) begin
            cmd_valid <= 1'b1;
            cmd_len   <= 8'(len - 16'd1);
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (falign) begin
            resync_err <= 1'b1;
            pend       <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (falign) begin
            resync_err <= 1'b1;
            pend       <= 1'b1;
          end
          if (burst_done) begin
            if (pend || falign) begin
              // Deferred restart: burst is finished, start the next buffer.
              pend      <= 1'b0;
              frame_idx <= fidx_nx;
              line      <= '0;
              offset    <= '0;
              hact      <= hactive;
              vact      <= vactive;
              fstride   <= frame_stride;
              lstride   <= line_stride;
              state     <= cfg_err ? WAIT_FRAME : WAIT_DATA;
            end else begin
              offset <= eol ? 16'd0 : offset_nx;
              line   <= eol ? line + 16'd1 : line;
              if (last_burst) begin
                frame_done <= 1'b1;
                frame_idx  <= fidx_nx;
                state      <= WAIT_FRAME;
              end else begin
                state <= WAIT_DATA;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_burst_sched.sv
// Scoreboard bench for wr_burst_sched: expected commands are queued when a
// frame is started and compared as the DUT hands each command off.
module tb_wr_burst_sched;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] FSTR = 32'h0010_0000;
  localparam logic [31:0] LSTR = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] vactive = 16'd2;
  logic [15:0] hactive = 16'd40;
  logic [31:0] base_addr = BASE;
  logic [31:0] frame_stride = FSTR;
  logic [31:0] line_stride = LSTR;
  logic        falign = 1'b0;
  logic [11:0] fifo_count = 12'd64;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        burst_done = 1'b0;
  logic [1:0]  frame_idx;
  logic        frame_done, resync_err, cfg_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0, chk_cnt = 0;
  int   acc_cnt = 0, fd_cnt = 0, rs_cnt = 0;
  int   done_cnt = 0, done_delay = 2;

  wr_burst_sched dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .enable       (enable),
    .vactive      (vactive),
    .hactive      (hactive),
    .base_addr    (base_addr),
    .frame_stride (frame_stride),
    .line_stride  (line_stride),
    .falign       (falign),
    .fifo_count   (fifo_count),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .burst_done   (burst_done),
    .frame_idx    (frame_idx),
    .frame_done   (frame_done),
    .resync_err   (resync_err),
    .cfg_err      (cfg_err)
  );

  always #5 clock = ~clock;

  // Monitor + memory-side responder, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    burst_done = 1'b0;
    if (!rst_n) begin
      done_cnt = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) burst_done = 1'b1;
      end
      if (frame_done) fd_cnt++;
      if (resync_err) rs_cnt++;
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        done_cnt = done_delay;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL cmd_unexpected: got addr %h len %0d, none expected", cmd_addr, cmd_len);
        end else begin
          e = exp_q.pop_front();
          if (cmd_addr !== e.addr || cmd_len !== e.len)
            $display("FAIL cmd_%0d: got addr %h len %0d, want addr %h len %0d",
                     acc_cnt, cmd_addr, cmd_len, e.addr, e.len);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic pulse_falign();
    falign = 1'b1;
    step(1);
    falign = 1'b0;
  endtask

  task automatic wait_acc(input int tgt);
    for (int i = 0; i < 400 && acc_cnt < tgt; i++) step(1);
  endtask

  task automatic wait_fd(input int tgt);
    for (int i = 0; i < 2000 && fd_cnt < tgt; i++) step(1);
  endtask

  // Reference walk of one frame: bursts of at most 16 beats, 4 bytes/beat.
  task automatic push_frame(input int f, input int h, input int v);
    for (int l = 0; l < v; l++) begin
      int off = 0;
      while (off < h) begin
        int   n;
        exp_t e;
        n = (h - off > 16) ? 16 : h - off;
        e.addr = BASE + 32'(f) * FSTR + 32'(l) * LSTR + 32'(off * 4);
        e.len  = 8'(n - 1);
        exp_q.push_back(e);
        off += n;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    chk_cnt++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else pass_cnt++;
    chk_cnt++; if (cmd_addr !== 32'd0) $display("FAIL rst_cmd_addr: got %h want 0", cmd_addr); else pass_cnt++;
    chk_cnt++; if (cmd_len !== 8'd0) $display("FAIL rst_cmd_len: got %0d want 0", cmd_len); else pass_cnt++;
    chk_cnt++; if (frame_idx !== 2'd0) $display("FAIL rst_frame_idx: got %0d want 0", frame_idx); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0 || resync_err !== 1'b0)
      $display("FAIL rst_pulses: got fd %b rs %b want 0 0", frame_done, resync_err); else pass_cnt++;
    chk_cnt++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err: got %b want 0", cfg_err); else pass_cnt++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_burst_frame();
    int acc0 = acc_cnt, fd0 = fd_cnt;
    hactive = 16'd40; vactive = 16'd2; fifo_count = 12'd64; cmd_ready = 1'b1;
    enable = 1'b1;
    step(3);
    push_frame(0, 40, 2);
    pulse_falign();
    wait_fd(fd0 + 1);
    step(3);
    chk_cnt++; if (acc_cnt - acc0 != 6) $display("FAIL frame_cmd_count: got %0d want 6", acc_cnt - acc0); else pass_cnt++;
    chk_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0); else pass_cnt++;
    chk_cnt++; if (frame_idx !== 2'd1) $display("FAIL frame_idx_after: got %0d want 1", frame_idx); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL frame_queue: got %0d left want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_fifo_threshold();
    int fd0 = fd_cnt;
    hactive = 16'd16; vactive = 16'd1; fifo_count = 12'd10;
    push_frame(1, 16, 1);
    pulse_falign();
    step(5);
    chk_cnt++; if (cmd_valid !== 1'b0) $display("FAIL thr_below: got cmd_valid %b want 0", cmd_valid); else pass_cnt++;
    fifo_count = 12'd16;
    step(1);
    chk_cnt++; if (cmd_valid !== 1'b1) $display("FAIL thr_latency: got cmd_valid %b want 1", cmd_valid); else pass_cnt++;
    wait_fd(fd0 + 1);
    step(2);
    fifo_count = 12'd64;
    chk_cnt++; if (frame_idx !== 2'd2) $display("FAIL thr_frame_idx: got %0d want 2", frame_idx); else pass_cnt++;
  endtask

  task automatic test_frame_wrap();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    hactive = 16'd16; vactive = 16'd1;
    for (int f = 0; f < 4; f++) begin
      int fd0 = fd_cnt;
      chk_cnt++; if (frame_idx !== 2'(f % 3))
        $display("FAIL wrap_idx_%0d: got %0d want %0d", f, frame_idx, f % 3); else pass_cnt++;
      push_frame(f % 3, 16, 1);
      pulse_falign();
      wait_fd(fd0 + 1);
      step(2);
    end
    chk_cnt++; if (frame_idx !== 2'd1) $display("FAIL wrap_final_idx: got %0d want 1", frame_idx); else pass_cnt++;
  endtask

  task automatic test_resync();
    int acc0 = acc_cnt, fd0 = fd_cnt, rs0 = rs_cnt;
    hactive = 16'd40; vactive = 16'd2; done_delay = 6;
    push_frame(1, 16, 1);
    pulse_falign();
    wait_acc(acc0 + 1);
    push_frame(2, 40, 2);
    falign = 1'b1;
    step(1);
    falign = 1'b0;
    wait_fd(fd0 + 1);
    step(3);
    done_delay = 2;
    chk_cnt++; if (rs_cnt - rs0 != 1) $display("FAIL resync_pulses: got %0d want 1", rs_cnt - rs0); else pass_cnt++;
    chk_cnt++; if (fd_cnt - fd0 != 1) $display("FAIL resync_frame_done: got %0d want 1", fd_cnt - fd0); else pass_cnt++;
    chk_cnt++; if (acc_cnt - acc0 != 7) $display("FAIL resync_cmds: got %0d want 7", acc_cnt - acc0); else pass_cnt++;
    chk_cnt++; if (frame_idx !== 2'd0) $display("FAIL resync_idx: got %0d want 0", frame_idx); else pass_cnt++;
  endtask

  task automatic test_cfg_err();
    int acc0 = acc_cnt;
    hactive = 16'd0;
    step(1);
    chk_cnt++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b want 1", cfg_err); else pass_cnt++;
    pulse_falign();
    step(10);
    chk_cnt++; if (acc_cnt != acc0 || cmd_valid !== 1'b0)
      $display("FAIL cfg_no_cmd: got %0d cmds valid %b want 0 0", acc_cnt - acc0, cmd_valid); else pass_cnt++;
    hactive = 16'd16;
    step(1);
    chk_cnt++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_clr: got %b want 0", cfg_err); else pass_cnt++;
  endtask

  task automatic test_enable_mid_burst();
    int acc0 = acc_cnt, fd0 = fd_cnt;
    hactive = 16'd16; vactive = 16'd4; done_delay = 8;
    push_frame(0, 16, 1);
    pulse_falign();
    wait_acc(acc0 + 1);
    enable = 1'b0;
    step(20);
    chk_cnt++; if (acc_cnt - acc0 != 1 || cmd_valid !== 1'b0)
      $display("FAIL dis_stop: got %0d cmds valid %b want 1 0", acc_cnt - acc0, cmd_valid); else pass_cnt++;
    chk_cnt++; if (fd_cnt != fd0) $display("FAIL dis_frame_done: got %0d want 0", fd_cnt - fd0); else pass_cnt++;
    done_delay = 2;
    enable = 1'b1;
    step(3);
    push_frame(0, 16, 4);
    pulse_falign();
    wait_fd(fd0 + 1);
    step(2);
    chk_cnt++; if (frame_idx !== 2'd1) $display("FAIL reen_idx: got %0d want 1", frame_idx); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL reen_queue: got %0d left want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    cmd_ready = 1'b0;
    hactive = 16'd16; vactive = 16'd1;
    pulse_falign();
    for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) step(1);
    chk_cnt++; if (cmd_valid !== 1'b1) $display("FAIL ar_valid_seen: got %b want 1", cmd_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (cmd_valid !== 1'b0) $display("FAIL ar_cmd_valid: got %b want 0", cmd_valid); else pass_cnt++;
    chk_cnt++; if (cmd_addr !== 32'd0 || cmd_len !== 8'd0)
      $display("FAIL ar_cmd: got addr %h len %0d want 0 0", cmd_addr, cmd_len); else pass_cnt++;
    chk_cnt++; if (frame_idx !== 2'd0) $display("FAIL ar_frame_idx: got %0d want 0", frame_idx); else pass_cnt++;
    step(2);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_burst_frame();
    test_fifo_threshold();
    test_frame_wrap();
    test_resync();
    test_cfg_err();
    test_enable_mid_burst();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
